// File: rtl/windowed_accumulator.sv
// Windowed sample accumulator: sums WINDOW accepted samples and presents
// each window total on a valid/ready output, optionally saturating.
module windowed_accumulator #(
  parameter int IN_W     = 5,
  parameter int OUT_W    = 14,
  parameter int WINDOW   = 6,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 1,
  localparam int CW      = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [IN_W-1:0]  in,
  input  logic             clear,
  output logic             in_ready,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_overflow,
  output logic [CW-1:0]    count
);

  typedef enum logic {ACC, HOLD} state_t;

  localparam logic [OUT_W-1:0] SMAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SMIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] UMAX = {OUT_W{1'b1}};

  state_t           state;
  logic [OUT_W-1:0] acc;
  logic             flag;

  logic [OUT_W:0]   ext_in;
  logic [OUT_W:0]   ext_acc;
  logic [OUT_W:0]   sum;
  logic             ovf;
  logic             last;
  logic [OUT_W-1:0] result;

  // One guard bit makes the sum exact, so overflow is read off the top bits.
  always_comb begin
    if (SIGNED != 0) begin
      ext_in  = {{(OUT_W+1-IN_W){in[IN_W-1]}}, in};
      ext_acc = {acc[OUT_W-1], acc};
    end else begin
      ext_in  = {{(OUT_W+1-IN_W){1'b0}}, in};
      ext_acc = {1'b0, acc};
    end
    sum = ext_acc + ext_in;
    if (SIGNED != 0)
      ovf = sum[OUT_W] ^ sum[OUT_W-1];
    else
      ovf = sum[OUT_W];
    result = sum[OUT_W-1:0];
    if (ovf && (SATURATE != 0)) begin
      if (SIGNED != 0)
        result = sum[OUT_W] ? SMIN : SMAX;
      else
        result = UMAX;
    end
    last = (count == CW'(WINDOW - 1));
  end

  assign in_ready = (state == ACC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ACC;
      acc          <= '0;
      count        <= '0;
      flag         <= 1'b0;
      out          <= '0;
      out_valid    <= 1'b0;
      out_overflow <= 1'b0;
    end else if (clear) begin
      state     <= ACC;
      acc       <= '0;
      count     <= '0;
      flag      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (en) begin
            if (last) begin
              out          <= result;
              out_overflow <= flag | ovf;
              out_valid    <= 1'b1;
              acc          <= '0;
              count        <= '0;
              flag         <= 1'b0;
              state        <= HOLD;
            end else begin
              acc   <= result;
              count <= count + 1'b1;
              flag  <= flag | ovf;
            end
          end
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_windowed_accumulator.sv
// Directed bench for windowed_accumulator: default, 8-bit saturating,
// 8-bit wrapping and signed configurations driven from shared inputs.
module tb_windowed_accumulator;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [4:0] in = '0;
  logic       clear = 1'b0;
  logic       out_ready = 1'b0;

  logic        rdy0, val0, ovf0;
  logic [13:0] out0;
  logic [2:0]  cnt0;

  logic        rdy1, val1, ovf1;
  logic [7:0]  out1;
  logic [4:0]  cnt1;

  logic        rdy2, val2, ovf2;
  logic [7:0]  out2;
  logic [4:0]  cnt2;

  logic        rdy3, val3, ovf3;
  logic [13:0] out3;
  logic [2:0]  cnt3;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  windowed_accumulator u_def (
    .clk(clk), .reset(reset), .en(en), .in(in), .clear(clear),
    .in_ready(rdy0), .out(out0), .out_valid(val0),
    .out_ready(out_ready), .out_overflow(ovf0), .count(cnt0)
  );

  windowed_accumulator #(.OUT_W(8), .WINDOW(16), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .en(en), .in(in), .clear(clear),
    .in_ready(rdy1), .out(out1), .out_valid(val1),
    .out_ready(out_ready), .out_overflow(ovf1), .count(cnt1)
  );

  windowed_accumulator #(.OUT_W(8), .WINDOW(16), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .in(in), .clear(clear),
    .in_ready(rdy2), .out(out2), .out_valid(val2),
    .out_ready(out_ready), .out_overflow(ovf2), .count(cnt2)
  );

  windowed_accumulator #(.SIGNED(1)) u_sgn (
    .clk(clk), .reset(reset), .en(en), .in(in), .clear(clear),
    .in_ready(rdy3), .out(out3), .out_valid(val3),
    .out_ready(out_ready), .out_overflow(ovf3), .count(cnt3)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] v);
    in = v;
    en = 1'b1;
    tick();
  endtask

  task automatic idle();
    en = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    en = 1'b0;
    clear = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_out", 32'(out0), 32'd0);
    check("rst_valid", 32'(val0), 32'd0);
    check("rst_ovf", 32'(ovf0), 32'd0);
    check("rst_count", 32'(cnt0), 32'd0);
    check("rst_ready", 32'(rdy0), 32'd1);

    // Back-to-back window with consumer ready
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) send(5'(10 + i));
    check("w1_out", 32'(out0), 32'd75);
    check("w1_valid", 32'(val0), 32'd1);
    check("w1_ovf", 32'(ovf0), 32'd0);
    check("w1_count", 32'(cnt0), 32'd0);
    check("w1_ready", 32'(rdy0), 32'd0);
    idle();
    check("w1_valid_drop", 32'(val0), 32'd0);
    check("w1_ready_back", 32'(rdy0), 32'd1);

    // Stalled consumer: samples during HOLD are dropped
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(5'(10 + i));
    for (int i = 0; i < 3; i++) begin
      send(5'd31);
      check("stall_ready", 32'(rdy0), 32'd0);
      check("stall_out", 32'(out0), 32'd75);
      check("stall_valid", 32'(val0), 32'd1);
      check("stall_count", 32'(cnt0), 32'd0);
    end
    out_ready = 1'b1;
    idle();
    check("stall_release", 32'(val0), 32'd0);
    for (int i = 0; i < 6; i++) send(5'd2);
    check("w2_out", 32'(out0), 32'd12);
    check("w2_valid", 32'(val0), 32'd1);

    // Gaps between samples do not count
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(5'(10 + i));
      if (i < 5) begin
        idle();
        check("gap_valid", 32'(val0), 32'd0);
        check("gap_count", 32'(cnt0), 32'(i + 1));
      end
    end
    check("gap_out", 32'(out0), 32'd75);
    check("gap_valid_hi", 32'(val0), 32'd1);
    idle();
    check("gap_valid_1cyc", 32'(val0), 32'd0);

    // 8-bit, 16-sample window of 31: saturate vs wrap
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(5'd31);
    check("sat_out", 32'(out1), 32'd255);
    check("sat_ovf", 32'(ovf1), 32'd1);
    check("sat_valid", 32'(val1), 32'd1);
    check("wrap_out", 32'(out2), 32'd240);
    check("wrap_ovf", 32'(ovf2), 32'd1);

    // Signed mode
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(5'b10000);
    check("sgn_neg_out", 32'(out3), 32'h3FA0);
    check("sgn_neg_ovf", 32'(ovf3), 32'd0);
    out_ready = 1'b1;
    idle();
    for (int i = 0; i < 3; i++) begin
      send(5'b10000);
      send(5'd15);
    end
    check("sgn_mix_out", 32'(out3), 32'h3FFD);
    check("sgn_mix_valid", 32'(val3), 32'd1);

    // Mid-window asynchronous reset
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) send(5'(10 + i));
    idle();
    for (int i = 0; i < 3; i++) send(5'd1);
    check("mid_count", 32'(cnt0), 32'd3);
    en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_out", 32'(out0), 32'd0);
    check("async_valid", 32'(val0), 32'd0);
    check("async_count", 32'(cnt0), 32'd0);
    #1 reset = 1'b0;

    // Synchronous clear keeps the previous result
    for (int i = 0; i < 6; i++) send(5'(10 + i));
    idle();
    for (int i = 0; i < 3; i++) send(5'd1);
    clear = 1'b1;
    send(5'd1);
    clear = 1'b0;
    check("clr_count", 32'(cnt0), 32'd0);
    check("clr_out", 32'(out0), 32'd75);
    check("clr_valid", 32'(val0), 32'd0);
    for (int i = 0; i < 6; i++) send(5'd1);
    check("clr_next_out", 32'(out0), 32'd6);
    check("clr_next_valid", 32'(val0), 32'd1);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/windowed_accumulator.md
Name: windowed_accumulator

Overview:
- Parametrised successor to the single-channel running accumulator used in the IMAC datapath.
- Sums a fixed window of WINDOW enabled input samples, with a signed or unsigned mode and optional saturation.
- Presents each completed window sum on a valid/ready output interface and stalls input while a result is pending.
- Sits between the column ADC/sense stage and the downstream activation/readout logic.

Parameters:
- IN_W, 5, input sample width.
- OUT_W, 14, output/accumulator width; must be > IN_W.
- WINDOW, 6, number of enabled samples per result; must be >= 1.
- SIGNED, 0, 1 = in and out are two's complement; 0 = unsigned.
- SATURATE, 1, 1 = clamp on overflow; 0 = wrap modulo 2^OUT_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  sample strobe; sample accepted when en && in_ready.
- in  input  IN_W  sample value.
- clear  input  1  synchronous abort/flush of the current window.
- in_ready  output  1  high when a sample can be accepted.
- out  output  OUT_W  last completed window sum.
- out_valid  output  1  out holds an unconsumed result.
- out_ready  input  1  consumer accepts result when out_valid && out_ready.
- out_overflow  output  1  overflow/saturation occurred in the window that produced out.
- count  output  $clog2(WINDOW+1)  samples accepted in the current window.

Behaviour:
- Reset (asynchronous, immediate): acc=0, count=0, out=0, out_valid=0, out_overflow=0, internal overflow flag=0, state=ACC, in_ready=1.
  - Reset mid-window discards all partial state.
- States:
  - ACC: in_ready=1.
  - HOLD: in_ready=0; en is ignored and samples are dropped, not queued.
- ACC, accept (en=1):
  - Extend in to OUT_W+1 bits: sign-extend if SIGNED, else zero-extend.
  - sum = acc + ext(in).
  - If sum is out of OUT_W range: set the sticky overflow flag. If SATURATE, clamp to the range limit: unsigned max 2^OUT_W-1; signed max 2^(OUT_W-1)-1, min -2^(OUT_W-1). Else keep the low OUT_W bits.
  - If count==WINDOW-1: out<=result, out_overflow<=flag|this overflow, out_valid<=1, acc<=0, count<=0, flag<=0, state->HOLD.
  - Otherwise: acc<=result, count<=count+1.
- ACC, en=0: no change. Gaps between samples are allowed and do not count.
- Latency: out/out_valid update on the same edge that accepts the WINDOW-th sample and are visible the following cycle.
- HOLD:
  - When out_valid && out_ready at an edge: out_valid<=0, state->ACC. in_ready rises the next cycle.
  - out and out_overflow keep their values until the next window completes.
- clear (synchronous, priority over en and out_ready): acc=0, count=0, flag=0, out_valid=0, state->ACC. out and out_overflow keep their values.
- WINDOW=1: every accepted sample produces a result. The ACC/HOLD alternation holds, so the maximum rate is one sample per 2 cycles with out_ready tied high.
- out_ready while out_valid=0: ignored.
- Every output is registered; there is no combinational path from inputs to outputs except none (in_ready derived from state register).

Test Plan:
- Defaults, in=10,11,12,13,14,15 with en=1 on 6 consecutive edges, out_ready=1 -> out=75, out_valid=1 for exactly 1 cycle, out_overflow=0, count returns to 0.
- Defaults, first window completes with out_ready=0 for 3 cycles while en=1 and in=31 -> in_ready=0, out stays 75 and out_valid stays 1. After out_ready=1: next window of 6×2 -> out=12.
- Same 6 samples with en low every other cycle -> out=75, out_valid asserted 1 cycle after the 6th accepted edge.
- OUT_W=8, WINDOW=16, in=31 ×16:
  - SATURATE=1 -> out=255, out_overflow=1.
  - SATURATE=0 -> out=240, out_overflow=1.
- SIGNED=1, in=5'b10000 (-16) ×6 -> out=14'h3FA0 (-96). Mixed -16, +15 ×3 pairs -> out=14'h3FFD (-3).
- 3 samples accepted, then reset pulsed mid-cycle -> out=0, out_valid=0, count=0 immediately.
  - Repeat with clear instead of reset -> count=0 and prior out retained.
  - Then 6 samples of 1 -> out=6.
